// File: rtl/vga_timing_gen_pkg.sv
// Shared timing types, standard VGA mode constant sets and width/total helpers.
// Pure declarations; no logic.
package vga_timing_gen_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h: '{16'd640, 16'd16, 16'd96, 16'd48},
        v: '{16'd480, 16'd10, 16'd2, 16'd33}
    };

    localparam vga_mode_t MODE_800X600_60 = '{
        h: '{16'd800, 16'd40, 16'd128, 16'd88},
        v: '{16'd600, 16'd1, 16'd4, 16'd23}
    };

    localparam vga_mode_t MODE_1024X768_60 = '{
        h: '{16'd1024, 16'd24, 16'd136, 16'd160},
        v: '{16'd768, 16'd3, 16'd6, 16'd29}
    };

    function automatic int axis_total(axis_timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the generator (master) and the pixel pipeline (slave).
// en flows towards the generator; everything else flows out of it.
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
) ();
    logic          en;
    logic          pix_tick;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic [15:0]   frame_cnt;

    modport master (
        input  en,
        output pix_tick, hcount, vcount, hsync, vsync, de, x, y,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        output en,
        input  pix_tick, hcount, vcount, hsync, vsync, de, x, y,
               line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// Modulo-N position counter for one raster axis, resetting to N-1 so the first step lands on 0.
// Exposes the next count and its active/sync window decode so the parent can register them.
module vga_axis_counter #(
    parameter int N          = 800,
    parameter int W          = 10,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         term,
    output logic         active_nxt,
    output logic         sync_nxt
);
    localparam int WP = W + 1;
    localparam logic [W-1:0]  LAST = W'(N - 1);
    // One spare bit so a window edge equal to N still compares correctly.
    localparam logic [WP-1:0] ACT_W = WP'(ACTIVE);
    localparam logic [WP-1:0] SS_W  = WP'(SYNC_START);
    localparam logic [WP-1:0] SE_W  = WP'(SYNC_END);

    logic [WP-1:0] nxt_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= LAST;
        end else begin
            count <= count_nxt;
        end
    end

    always_comb begin
        term      = (count == LAST);
        count_nxt = count;
        if (step) begin
            count_nxt = term ? '0 : count + 1'b1;
        end
    end

    assign nxt_ext    = {1'b0, count_nxt};
    assign active_nxt = (nxt_ext < ACT_W);
    assign sync_nxt   = (nxt_ext >= SS_W) && (nxt_ext < SE_W);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock-enable divider and run/freeze.
// All outputs registered; syncs/de/x/y decoded from next counts so they align with hcount/vcount.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 1
) (
    input logic               clk,
    input logic               reset,
    vga_timing_gen_if.master  vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);
    localparam int DW      = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] d;
    logic          tick;
    logic          line_wrap;
    logic          frame_wrap;

    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic          h_term, v_term;
    logic          h_act_nxt, v_act_nxt;
    logic          h_sync_nxt, v_sync_nxt;
    logic          de_nxt;

    logic          pix_tick_q;
    logic          line_start_q;
    logic          frame_start_q;
    logic          hsync_q;
    logic          vsync_q;
    logic          de_q;
    logic [HW-1:0] x_q;
    logic [VW-1:0] y_q;
    logic [15:0]   frame_cnt_q;

    assign tick       = vid.en && (d == D_LAST);
    assign line_wrap  = tick && h_term;
    assign frame_wrap = line_wrap && v_term;
    assign de_nxt     = h_act_nxt && v_act_nxt;

    vga_axis_counter #(
        .N          (H_TOTAL),
        .W          (HW),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h (
        .clk        (clk),
        .reset      (reset),
        .step       (tick),
        .count      (h_cnt),
        .count_nxt  (h_nxt),
        .term       (h_term),
        .active_nxt (h_act_nxt),
        .sync_nxt   (h_sync_nxt)
    );

    vga_axis_counter #(
        .N          (V_TOTAL),
        .W          (VW),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v (
        .clk        (clk),
        .reset      (reset),
        .step       (line_wrap),
        .count      (v_cnt),
        .count_nxt  (v_nxt),
        .term       (v_term),
        .active_nxt (v_act_nxt),
        .sync_nxt   (v_sync_nxt)
    );

    // Without a tick the next counts equal the current ones, so the decoded
    // outputs re-register the same values and hold naturally while frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            d             <= '0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_cnt_q   <= 16'hFFFF;
        end else begin
            if (vid.en) begin
                d <= tick ? '0 : d + 1'b1;
            end
            pix_tick_q    <= tick;
            line_start_q  <= line_wrap;
            frame_start_q <= frame_wrap;
            hsync_q       <= h_sync_nxt ? HSYNC_POL : ~HSYNC_POL;
            vsync_q       <= v_sync_nxt ? VSYNC_POL : ~VSYNC_POL;
            de_q          <= de_nxt;
            x_q           <= de_nxt ? h_nxt : '0;
            y_q           <= de_nxt ? v_nxt : '0;
            if (frame_wrap) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign vid.pix_tick    = pix_tick_q;
    assign vid.hcount      = h_cnt;
    assign vid.vcount      = v_cnt;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two generators: default 640x480 at CLK_DIV=1, and a tiny 16x10 mode at CLK_DIV=4 with positive syncs.
// Directed expectations are queued with their cycle stamp; a negedge monitor retires them.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam vga_mode_t MA = MODE_640X480_60;
    localparam int HW_A = cnt_width(axis_total(MA.h));
    localparam int VW_A = cnt_width(axis_total(MA.v));
    localparam int HW_B = cnt_width(16);
    localparam int VW_B = cnt_width(10);

    localparam int F_H = 0, F_V = 1, F_HS = 2, F_VS = 3, F_DE = 4, F_X = 5;
    localparam int F_Y = 6, F_LS = 7, F_FS = 8, F_FC = 9, F_PT = 10;
    localparam int B = 16;

    typedef struct {
        int    cyc;
        int    sel;
        int    exp;
        string name;
    } chk_t;

    logic clk;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    chk_t sbq[$];

    vga_timing_gen_if #(.HW(HW_A), .VW(VW_A)) va ();
    vga_timing_gen_if #(.HW(HW_B), .VW(VW_B)) vb ();

    vga_timing_gen #(
        .H_ACTIVE(int'(MA.h.active)), .H_FP(int'(MA.h.fp)),
        .H_SYNC(int'(MA.h.sync)), .H_BP(int'(MA.h.bp)),
        .V_ACTIVE(int'(MA.v.active)), .V_FP(int'(MA.v.fp)),
        .V_SYNC(int'(MA.v.sync)), .V_BP(int'(MA.v.bp)),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1)
    ) u_a (
        .clk   (clk),
        .reset (rst_a),
        .vid   (va)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(4)
    ) u_b (
        .clk   (clk),
        .reset (rst_b),
        .vid   (vb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(int sel);
        case (sel)
            F_H:      return int'(va.hcount);
            F_V:      return int'(va.vcount);
            F_HS:     return int'(va.hsync);
            F_VS:     return int'(va.vsync);
            F_DE:     return int'(va.de);
            F_X:      return int'(va.x);
            F_Y:      return int'(va.y);
            F_LS:     return int'(va.line_start);
            F_FS:     return int'(va.frame_start);
            F_FC:     return int'(va.frame_cnt);
            F_PT:     return int'(va.pix_tick);
            B + F_H:  return int'(vb.hcount);
            B + F_V:  return int'(vb.vcount);
            B + F_HS: return int'(vb.hsync);
            B + F_VS: return int'(vb.vsync);
            B + F_DE: return int'(vb.de);
            B + F_X:  return int'(vb.x);
            B + F_Y:  return int'(vb.y);
            B + F_LS: return int'(vb.line_start);
            B + F_FS: return int'(vb.frame_start);
            B + F_FC: return int'(vb.frame_cnt);
            B + F_PT: return int'(vb.pix_tick);
            default:  return -1;
        endcase
    endfunction

    task automatic ex(input int c, input int sel, input int v, input string nm);
        chk_t e;
        e.cyc  = c;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic to_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: retires every expectation whose cycle has arrived; late ones count as failures.
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                int act;
                act = sample(sbq[i].sel);
                total++;
                if (sbq[i].cyc < cyc || act != sbq[i].exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%0d want=%0d",
                             sbq[i].name, sbq[i].cyc, act, sbq[i].exp);
                end
                sbq.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        va.en = 1'b1;
        vb.en = 1'b1;

        // Reset-state values on both generators.
        ex(3, F_H, 799, "a_rst_h");     ex(3, F_V, 524, "a_rst_v");
        ex(3, F_HS, 1, "a_rst_hs");     ex(3, F_VS, 1, "a_rst_vs");
        ex(3, F_DE, 0, "a_rst_de");     ex(3, F_X, 0, "a_rst_x");
        ex(3, F_Y, 0, "a_rst_y");       ex(3, F_FC, 65535, "a_rst_fc");
        ex(3, F_FS, 0, "a_rst_fs");     ex(3, F_LS, 0, "a_rst_ls");
        ex(3, F_PT, 0, "a_rst_pt");
        ex(3, B+F_H, 15, "b_rst_h");    ex(3, B+F_V, 9, "b_rst_v");
        ex(3, B+F_HS, 0, "b_rst_hs");   ex(3, B+F_VS, 0, "b_rst_vs");
        ex(3, B+F_DE, 0, "b_rst_de");   ex(3, B+F_FC, 65535, "b_rst_fc");
        ex(3, B+F_PT, 0, "b_rst_pt");

        to_cyc(5);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // A: first pixel right after release, then one line of boundaries.
        ex(6, F_H, 0, "a_first_h");     ex(6, F_V, 0, "a_first_v");
        ex(6, F_DE, 1, "a_first_de");   ex(6, F_FS, 1, "a_first_fs");
        ex(6, F_LS, 1, "a_first_ls");   ex(6, F_FC, 0, "a_first_fc");
        ex(6, F_PT, 1, "a_first_pt");   ex(6, F_HS, 1, "a_first_hs");
        ex(6, F_VS, 1, "a_first_vs");   ex(6, F_X, 0, "a_first_x");
        ex(7, F_H, 1, "a_h1");          ex(7, F_FS, 0, "a_fs_width");
        ex(7, F_LS, 0, "a_ls_width");   ex(7, F_X, 1, "a_x1");
        ex(645, F_DE, 1, "a_de_639");   ex(645, F_X, 639, "a_x_639");
        ex(646, F_DE, 0, "a_de_640");   ex(646, F_X, 0, "a_x_640");
        ex(646, F_H, 640, "a_h_640");
        ex(661, F_HS, 1, "a_hs_655");   ex(662, F_HS, 0, "a_hs_656");
        ex(662, F_H, 656, "a_h_656");   ex(757, F_HS, 0, "a_hs_751");
        ex(758, F_HS, 1, "a_hs_752");
        ex(805, F_H, 799, "a_h_799");   ex(805, F_V, 0, "a_v_l0end");
        ex(805, F_LS, 0, "a_ls_799");   ex(806, F_H, 0, "a_l1_h");
        ex(806, F_V, 1, "a_l1_v");      ex(806, F_LS, 1, "a_l1_ls");
        ex(806, F_FS, 0, "a_l1_fs");    ex(806, F_Y, 1, "a_l1_y");
        ex(806, F_DE, 1, "a_l1_de");

        // B: divider by 4, each count held 4 clks, tiny frame of 640 clks.
        ex(8, B+F_H, 15, "b_pre_h");    ex(8, B+F_PT, 0, "b_pre_pt");
        ex(8, B+F_FS, 0, "b_pre_fs");
        ex(9, B+F_H, 0, "b_first_h");   ex(9, B+F_V, 0, "b_first_v");
        ex(9, B+F_FS, 1, "b_first_fs"); ex(9, B+F_LS, 1, "b_first_ls");
        ex(9, B+F_PT, 1, "b_first_pt"); ex(9, B+F_FC, 0, "b_first_fc");
        ex(9, B+F_DE, 1, "b_first_de"); ex(9, B+F_HS, 0, "b_first_hs");
        ex(10, B+F_H, 0, "b_hold_h");   ex(10, B+F_FS, 0, "b_fs_width");
        ex(10, B+F_LS, 0, "b_ls_width"); ex(10, B+F_PT, 0, "b_pt_gap");
        ex(12, B+F_H, 0, "b_hold_h3");  ex(12, B+F_PT, 0, "b_pt_gap3");
        ex(13, B+F_H, 1, "b_h1");       ex(13, B+F_PT, 1, "b_pt_4th");
        ex(13, B+F_X, 1, "b_x1");
        ex(37, B+F_DE, 1, "b_de_7");    ex(37, B+F_X, 7, "b_x_7");
        ex(41, B+F_DE, 0, "b_de_8");    ex(41, B+F_X, 0, "b_x_8");
        ex(41, B+F_H, 8, "b_h_8");
        ex(45, B+F_HS, 0, "b_hs_9");    ex(49, B+F_HS, 1, "b_hs_10");
        ex(49, B+F_H, 10, "b_h_10");    ex(57, B+F_HS, 1, "b_hs_12");
        ex(61, B+F_HS, 0, "b_hs_13");
        ex(73, B+F_LS, 1, "b_l1_ls");   ex(73, B+F_H, 0, "b_l1_h");
        ex(73, B+F_V, 1, "b_l1_v");     ex(73, B+F_Y, 1, "b_l1_y");
        ex(74, B+F_LS, 0, "b_l1_lsw");
        ex(393, B+F_DE, 0, "b_v6_de");  ex(393, B+F_Y, 0, "b_v6_y");
        ex(393, B+F_V, 6, "b_v6_v");
        ex(453, B+F_VS, 0, "b_vs_6end"); ex(453, B+F_H, 15, "b_vs_6end_h");
        ex(457, B+F_VS, 1, "b_vs_7");   ex(457, B+F_V, 7, "b_v_7");
        ex(581, B+F_VS, 1, "b_vs_8end"); ex(585, B+F_VS, 0, "b_vs_9");
        ex(585, B+F_V, 9, "b_v_9");
        ex(648, B+F_FS, 0, "b_f1_pre_fs"); ex(648, B+F_FC, 0, "b_f1_pre_fc");
        ex(649, B+F_FS, 1, "b_f1_fs");  ex(649, B+F_FC, 1, "b_f1_fc");
        ex(649, B+F_H, 0, "b_f1_h");    ex(649, B+F_V, 0, "b_f1_v");
        ex(650, B+F_FS, 0, "b_f1_fsw");
        ex(1289, B+F_FS, 1, "b_f2_fs"); ex(1289, B+F_FC, 2, "b_f2_fc");
        ex(1498, B+F_H, 4, "b_mid_h");  ex(1498, B+F_V, 3, "b_mid_v");
        ex(1498, B+F_DE, 1, "b_mid_de"); ex(1498, B+F_X, 4, "b_mid_x");
        ex(1498, B+F_Y, 3, "b_mid_y");  ex(1498, B+F_FC, 2, "b_mid_fc");

        // B: reset mid-frame with en low must still take effect.
        to_cyc(1498);
        rst_b = 1'b1;
        vb.en = 1'b0;
        ex(1499, B+F_H, 15, "b_mr_h");  ex(1499, B+F_V, 9, "b_mr_v");
        ex(1499, B+F_DE, 0, "b_mr_de"); ex(1499, B+F_X, 0, "b_mr_x");
        ex(1499, B+F_Y, 0, "b_mr_y");   ex(1499, B+F_FC, 65535, "b_mr_fc");
        ex(1499, B+F_HS, 0, "b_mr_hs"); ex(1499, B+F_PT, 0, "b_mr_pt");
        ex(1500, B+F_H, 15, "b_mr_h2");
        ex(1503, B+F_H, 15, "b_rel_pre_h"); ex(1503, B+F_FS, 0, "b_rel_pre_fs");
        ex(1504, B+F_H, 0, "b_rel_h");  ex(1504, B+F_V, 0, "b_rel_v");
        ex(1504, B+F_FS, 1, "b_rel_fs"); ex(1504, B+F_FC, 0, "b_rel_fc");
        ex(1504, B+F_LS, 1, "b_rel_ls"); ex(1504, B+F_DE, 1, "b_rel_de");
        to_cyc(1500);
        rst_b = 1'b0;
        vb.en = 1'b1;

        // A: freeze for 10 clks at (300,7).
        ex(5906, F_H, 300, "a_fz_h");   ex(5906, F_V, 7, "a_fz_v");
        ex(5906, F_PT, 1, "a_fz_pt");   ex(5906, F_X, 300, "a_fz_x");
        ex(5906, F_Y, 7, "a_fz_y");
        ex(5907, F_H, 300, "a_fz1_h");  ex(5907, F_PT, 0, "a_fz1_pt");
        ex(5907, F_LS, 0, "a_fz1_ls");
        ex(5911, F_H, 300, "a_fz5_h");  ex(5911, F_V, 7, "a_fz5_v");
        ex(5911, F_DE, 1, "a_fz5_de");  ex(5911, F_PT, 0, "a_fz5_pt");
        ex(5916, F_H, 300, "a_fz10_h"); ex(5916, F_X, 300, "a_fz10_x");
        ex(5916, F_PT, 0, "a_fz10_pt"); ex(5916, F_FC, 0, "a_fz10_fc");
        ex(5916, F_HS, 1, "a_fz10_hs"); ex(5916, F_FS, 0, "a_fz10_fs");
        ex(5917, F_H, 301, "a_run_h");  ex(5917, F_X, 301, "a_run_x");
        ex(5917, F_PT, 1, "a_run_pt");
        to_cyc(5906);
        va.en = 1'b0;
        to_cyc(5916);
        va.en = 1'b1;

        to_cyc(5925);
        if (sbq.size() != 0) begin
            $display("FAIL leftover expectations: got=%0d want=0", sbq.size());
            total += sbq.size();
            bad   += sbq.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
